gs_rect_writer: RTL and testbench

Upstream pixel source for the grayscale VGA framebuffer: on a start pulse it latches a rectangle (origin, size, fill and border gray levels) and streams it row-major, one pixel per cycle, as x/y/pixel_GS/pixel_write beats into the framebuffer write port. It replaces the free-running pixel counter plus combinational border logic in the top level with a commandable, handshaked, screen-clipped drawing engine.

---
 rtl/gs_rect_pkg.sv | 16 +
 rtl/gs_rect_writer_scan_counter.sv | 66 ++++++
 rtl/gs_rect_writer.sv | 167 ++++++++++++++++
 tb/tb_gs_rect_writer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/gs_rect_pkg.sv
// Shared types and screen constants for the rectangle pixel writer.
package gs_rect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [10:0] coord_t;
    typedef logic [7:0]  gs_t;

    localparam int unsigned DEF_SCREEN_W = 640;
    localparam int unsigned DEF_SCREEN_H = 480;

endpackage

// File: rtl/gs_rect_writer_scan_counter.sv
// Column/row walker for the rectangle; flags describe the position the counter moves to this cycle.
module rect_scan_counter
    import gs_rect_pkg::*;
(
    input  logic   clock,
    input  logic   reset_n,
    input  logic   load,
    input  logic   advance,
    input  coord_t width_in,
    input  coord_t height_in,
    output coord_t col_nxt,
    output coord_t row_nxt,
    output logic   first_col,
    output logic   last_col,
    output logic   first_row,
    output logic   last_row,
    output logic   last_pixel
);

    coord_t w_q, w_d, h_q, h_d;
    coord_t col_q, col_d, row_q, row_d;

    always_comb begin
        w_d   = w_q;
        h_d   = h_q;
        col_d = col_q;
        row_d = row_q;
        if (load) begin
            w_d   = width_in;
            h_d   = height_in;
            col_d = '0;
            row_d = '0;
        end else if (advance) begin
            if (col_q == w_q - 11'd1) begin
                col_d = '0;
                row_d = row_q + 11'd1;
            end else begin
                col_d = col_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            w_q   <= '0;
            h_q   <= '0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            w_q   <= w_d;
            h_q   <= h_d;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Next-position flags let the top register pixel_GS together with the coordinate.
    assign col_nxt    = col_d;
    assign row_nxt    = row_d;
    assign first_col  = (col_d == '0);
    assign last_col   = (col_d == w_d - 11'd1);
    assign first_row  = (row_d == '0);
    assign last_row   = (row_d == h_d - 11'd1);
    assign last_pixel = (col_q == w_q - 11'd1) && (row_q == h_q - 11'd1);

endmodule

// File: rtl/gs_rect_writer.sv
// Commandable, handshaked, screen-clipped rectangle writer for the grayscale framebuffer.
// Optional border shading is built when GS_RECT_BORDER_EN is defined.
module gs_rect_writer
    import gs_rect_pkg::*;
#(
    parameter int unsigned SCREEN_W = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H = DEF_SCREEN_H
)
(
    input  logic   clock,
    input  logic   reset_n,
    input  logic   start,
    input  coord_t x0,
    input  coord_t y0,
    input  coord_t width,
    input  coord_t height,
    input  gs_t    fill_gs,
    input  gs_t    border_gs,
    input  logic   pixel_ready,
    output coord_t x,
    output coord_t y,
    output gs_t    pixel_GS,
    output logic   pixel_write,
    output logic   busy,
    output logic   done
);

    localparam logic [11:0] SCR_W = 12'(SCREEN_W);
    localparam logic [11:0] SCR_H = 12'(SCREEN_H);

    state_t state_q, state_d;
    coord_t x0_q, x0_d, y0_q, y0_d;
    gs_t    fill_q, fill_d, border_q, border_d;
    coord_t x_q, x_d, y_q, y_d;
    gs_t    gs_q, gs_d;
    logic   pw_q, pw_d, busy_q, busy_d, done_q, done_d;

    logic   load, advance;
    coord_t col_nxt, row_nxt;
    logic   first_col, last_col, first_row, last_row, last_pixel;
    logic [11:0] xs, ys;
    logic   clipped;
    gs_t    beat_gs;

    assign load    = (state_q == IDLE) && start;
    assign advance = (state_q == SCAN) && (!pw_q || pixel_ready);

    assign x0_d     = load ? x0        : x0_q;
    assign y0_d     = load ? y0        : y0_q;
    assign fill_d   = load ? fill_gs   : fill_q;
    assign border_d = load ? border_gs : border_q;

    rect_scan_counter u_cnt (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (load),
        .advance    (advance),
        .width_in   (width),
        .height_in  (height),
        .col_nxt    (col_nxt),
        .row_nxt    (row_nxt),
        .first_col  (first_col),
        .last_col   (last_col),
        .first_row  (first_row),
        .last_row   (last_row),
        .last_pixel (last_pixel)
    );

    // 12-bit sums so an origin near 2047 plus an offset cannot wrap back on-screen.
    assign xs      = {1'b0, x0_d} + {1'b0, col_nxt};
    assign ys      = {1'b0, y0_d} + {1'b0, row_nxt};
    assign clipped = (xs >= SCR_W) || (ys >= SCR_H);

`ifdef GS_RECT_BORDER_EN
    assign beat_gs = (first_col || last_col || first_row || last_row) ? border_d : fill_d;
`else
    logic unused_border;
    assign unused_border = ^{border_d, first_col, last_col, first_row, last_row};
    assign beat_gs = fill_d;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        gs_d    = gs_q;
        pw_d    = pw_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (width == '0 || height == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SCAN;
                        x_d     = xs[10:0];
                        y_d     = ys[10:0];
                        gs_d    = beat_gs;
                        pw_d    = !clipped;
                    end
                end
            end
            SCAN: begin
                if (advance) begin
                    if (last_pixel) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pw_d    = 1'b0;
                    end else begin
                        x_d  = xs[10:0];
                        y_d  = ys[10:0];
                        gs_d = beat_gs;
                        pw_d = !clipped;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                pw_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            fill_q   <= '0;
            border_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            gs_q     <= '0;
            pw_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            fill_q   <= fill_d;
            border_q <= border_d;
            x_q      <= x_d;
            y_q      <= y_d;
            gs_q     <= gs_d;
            pw_q     <= pw_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign pixel_GS    = gs_q;
    assign pixel_write = pw_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_gs_rect_writer.sv
// Table-driven bench for gs_rect_writer with a beat scoreboard and a few hand sequences.
module tb_gs_rect_writer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] x0 = '0, y0 = '0, width = '0, height = '0;
    logic [7:0]  fill_gs = '0, border_gs = '0;
    logic        pixel_ready = 1'b1;
    logic [10:0] x, y;
    logic [7:0]  pixel_GS;
    logic        pixel_write, busy, done;

    int total = 0;
    int bad   = 0;

    gs_rect_writer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .x0          (x0),
        .y0          (y0),
        .width       (width),
        .height      (height),
        .fill_gs     (fill_gs),
        .border_gs   (border_gs),
        .pixel_ready (pixel_ready),
        .x           (x),
        .y           (y),
        .pixel_GS    (pixel_GS),
        .pixel_write (pixel_write),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x0; int y0; int w; int h;
        int fill; int border;
        int stall_start; int stall_len;
        int restart_cyc;
        bit start_at_done;
        int exp_done;
    } cmd_t;

    typedef struct { int x; int y; int gs; } beat_t;

    cmd_t  tbl[8];
    beat_t q[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_gs(input cmd_t c, input int col, input int row);
`ifdef GS_RECT_BORDER_EN
        if (col == 0 || row == 0 || col == c.w - 1 || row == c.h - 1) return c.border;
`endif
        return c.fill;
    endfunction

    task automatic push_expected(input cmd_t c);
        beat_t b;
        for (int r = 0; r < c.h; r++) begin
            for (int cc = 0; cc < c.w; cc++) begin
                b.x  = c.x0 + cc;
                b.y  = c.y0 + r;
                b.gs = model_gs(c, cc, r);
                if (b.x < 640 && b.y < 480) q.push_back(b);
            end
        end
    endtask

    // Called at a negedge; returns at the negedge following the post-done cycle.
    task automatic run_cmd(input cmd_t c, input int idx);
        beat_t b;
        bit    seen_done;
        x0 = 11'(c.x0); y0 = 11'(c.y0);
        width = 11'(c.w); height = 11'(c.h);
        fill_gs = 8'(c.fill); border_gs = 8'(c.border);
        start = 1'b1;
        pixel_ready = 1'b1;
        push_expected(c);
        seen_done = 1'b0;
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= 300 && !seen_done; k++) begin
            pixel_ready = !(k >= c.stall_start && k < c.stall_start + c.stall_len);
            start = (k == c.restart_cyc);
            if (start) begin
                x0 = 11'd300; y0 = 11'd300; width = 11'd9; height = 11'd9;
            end
            if (pixel_write) begin
                if (q.size() == 0) begin
                    check($sformatf("cmd%0d extra_beat_x", idx), int'(x), -1);
                end else if (pixel_ready) begin
                    b = q.pop_front();
                    check($sformatf("cmd%0d beat_x", idx), int'(x), b.x);
                    check($sformatf("cmd%0d beat_y", idx), int'(y), b.y);
                    check($sformatf("cmd%0d beat_gs", idx), int'(pixel_GS), b.gs);
                end else begin
                    check($sformatf("cmd%0d hold_x", idx), int'(x), q[0].x);
                    check($sformatf("cmd%0d hold_y", idx), int'(y), q[0].y);
                    check($sformatf("cmd%0d hold_gs", idx), int'(pixel_GS), q[0].gs);
                end
            end
            if (done) begin
                seen_done = 1'b1;
                check($sformatf("cmd%0d done_cycle", idx), k, c.exp_done);
                check($sformatf("cmd%0d busy_at_done", idx), int'(busy), 1);
                start = c.start_at_done;
            end
            @(negedge clock);
        end
        start = 1'b0;
        if (!seen_done) check($sformatf("cmd%0d timeout", idx), 0, 1);
        check($sformatf("cmd%0d busy_after", idx), int'(busy), 0);
        check($sformatf("cmd%0d done_after", idx), int'(done), 0);
        check($sformatf("cmd%0d write_after", idx), int'(pixel_write), 0);
        check($sformatf("cmd%0d missing_beats", idx), q.size(), 0);
        q.delete();
        @(negedge clock);
    endtask

    cmd_t fresh;

    initial begin
        //          x0   y0   w  h  fill  border stall  len rst  at_done done
        tbl[0] = '{ 10,  20,  3, 2, 'h40, 'hFF,  0,     0,  0,   1'b0,   7};
        tbl[1] = '{ 0,   0,   4, 4, 'h40, 'hFF,  0,     0,  0,   1'b0,   17};
        tbl[2] = '{ 638, 0,   4, 1, 'h21, 'hEE,  0,     0,  0,   1'b0,   5};
        tbl[3] = '{ 100, 50,  3, 2, 'h55, 'hAA,  2,     3,  0,   1'b0,   10};
        tbl[4] = '{ 7,   9,   0, 5, 'h11, 'h22,  0,     0,  0,   1'b0,   1};
        tbl[5] = '{ 5,   5,   3, 3, 'h33, 'hCC,  0,     0,  3,   1'b0,   10};
        tbl[6] = '{ 7,   7,   2, 1, 'h44, 'h99,  0,     0,  0,   1'b1,   3};
        tbl[7] = '{ 0,   478, 2, 4, 'h66, 'h77,  0,     0,  0,   1'b0,   9};

        #2;
        check("reset_x", int'(x), 0);
        check("reset_gs", int'(pixel_GS), 0);
        check("reset_write", int'(pixel_write), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 8; i++) run_cmd(tbl[i], i);

        // Abort mid-scan with reset, then redraw from the origin.
        x0 = 11'd0; y0 = 11'd0; width = 11'd4; height = 11'd4;
        fill_gs = 8'h12; border_gs = 8'h34;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        check("pre_reset_busy", int'(busy), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_write", int'(pixel_write), 0);
        check("async_busy", int'(busy), 0);
        check("async_done", int'(done), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_after_reset", int'(busy), 0);
        fresh = '{ 20, 30, 2, 2, 'h5A, 'hA5, 0, 0, 0, 1'b0, 5};
        run_cmd(fresh, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
